// File: rtl/signed_minmax_tracker.sv
// Frame-based signed min/max/count tracker with a valid/ready handshake on
// both sides and a compare of the final sample against the one before it.
module signed_minmax_tracker #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic [CNTW-1:0]  cnt_out,
  output logic             gt_out,
  output logic             eq_out,
  output logic             lt_out
);

  typedef enum logic [1:0] {
    EMPTY,
    ACCUM,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] sdin;
  logic signed [WIDTH-1:0] min_q, max_q, prev_q;
  logic signed [WIDTH-1:0] min_d, max_d, ref_v;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic                    accept, first, sat;

  assign sdin   = din;
  assign accept = in_valid && in_ready;
  assign first  = (state_q == EMPTY);
  assign sat    = (cnt_q == {CNTW{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n)   state_q <= EMPTY;
    else if (clr) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:
        if (accept) state_d = in_last ? HOLD : ACCUM;
      ACCUM:
        if (accept && in_last) state_d = HOLD;
      HOLD:
        if (out_ready) state_d = EMPTY;
      default:
        state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (state_q)
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // The first sample of a frame seeds min/max and compares equal to itself.
  always_comb begin
    min_d = (first || sdin < min_q) ? sdin : min_q;
    max_d = (first || sdin > max_q) ? sdin : max_q;
    ref_v = first ? sdin : prev_q;
    if (first)    cnt_d = CNTW'(1);
    else if (sat) cnt_d = cnt_q;
    else          cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      min_q  <= '0;
      max_q  <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      min_q  <= min_d;
      max_q  <= max_d;
      prev_q <= sdin;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_out <= '0;
      max_out <= '0;
      cnt_out <= '0;
      gt_out  <= 1'b0;
      eq_out  <= 1'b0;
      lt_out  <= 1'b0;
    end else if (!clr && accept && in_last) begin
      min_out <= min_d;
      max_out <= max_d;
      cnt_out <= cnt_d;
      gt_out  <= (sdin > ref_v);
      eq_out  <= (sdin == ref_v);
      lt_out  <= (sdin < ref_v);
    end
  end

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Directed bench for signed_minmax_tracker; a second instance with CNTW=2
// shares the stimulus to observe count saturation.
module tb_signed_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_last, out_ready;
  logic [3:0] din;
  logic       in_ready, out_valid, gt_out, eq_out, lt_out;
  logic [3:0] min_out, max_out;
  logic [7:0] cnt_out;
  logic       in_ready2, out_valid2, gt2, eq2, lt2;
  logic [3:0] min2, max2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_minmax_tracker #(.WIDTH(4), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .min_out(min_out), .max_out(max_out), .cnt_out(cnt_out),
    .gt_out(gt_out), .eq_out(eq_out), .lt_out(lt_out)
  );

  signed_minmax_tracker #(.WIDTH(4), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready2),
    .din(din), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready),
    .min_out(min2), .max_out(max2), .cnt_out(cnt2),
    .gt_out(gt2), .eq_out(eq2), .lt_out(lt2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    din      = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag,
                               input logic [3:0] mn,
                               input logic [3:0] mx,
                               input logic [7:0] cn,
                               input logic [2:0] gel);
    @(negedge clk);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".min"}, min_out, mn);
    check({tag, ".max"}, max_out, mx);
    check({tag, ".cnt"}, cnt_out, cn);
    check({tag, ".gel"}, {gt_out, eq_out, lt_out}, gel);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; out_ready = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.valid", out_valid, 0);
    check("rst.minmax", {min_out, max_out}, 0);
    check("rst.cnt", cnt_out, 0);
    check("rst.gel", {gt_out, eq_out, lt_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready", in_ready, 1);

    // Mixed-sign frame, consumer always ready
    out_ready = 1'b1;
    send(4'h2, 0); send(4'hD, 0); send(4'h7, 0); send(4'h8, 1);
    expect_result("f1", 4'h8, 4'h7, 8'd4, 3'b001);
    @(negedge clk);
    check("f1.drop", out_valid, 0);
    check("f1.ready", in_ready, 1);
    check("f1.hold", min_out, 4'h8);

    // Single-sample frame
    send(4'hE, 1);
    expect_result("f2", 4'hE, 4'hE, 8'd1, 3'b010);
    @(negedge clk);
    check("f2.drop", out_valid, 0);

    // Backpressure: held result, offered samples ignored
    out_ready = 1'b0;
    send(4'hF, 0); send(4'hF, 1);
    expect_result("f3", 4'hF, 4'hF, 8'd2, 3'b010);
    check("f3.ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; din = 4'h0; in_last = 1'b1;
      @(negedge clk);
      check("f3.bp.valid", out_valid, 1);
      check("f3.bp.ready", in_ready, 0);
      check("f3.bp.out", {min_out, max_out, cnt_out}, {4'hF, 4'hF, 8'd2});
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("f3.rel.valid", out_valid, 0);
    check("f3.rel.ready", in_ready, 1);

    // Signed ordering across the sign boundary
    send(4'h1, 0); send(4'hF, 1);
    expect_result("f4", 4'hF, 4'h1, 8'd2, 3'b001);
    send(4'hF, 0); send(4'h1, 1);
    expect_result("f5", 4'hF, 4'h1, 8'd2, 3'b100);

    // Five samples: full count on dut, saturated on dut2
    send(4'h3, 0); send(4'hF, 0); send(4'h5, 0);
    send(4'h0, 0); send(4'h4, 1);
    expect_result("f6", 4'hF, 4'h5, 8'd5, 3'b100);
    check("f6.sat.valid", out_valid2, 1);
    check("f6.sat.cnt", cnt2, 3);
    check("f6.sat.min", min2, 4'hF);

    // Abort mid-frame, with a last sample offered alongside clr
    send(4'h5, 0); send(4'h6, 0);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; din = 4'h9; in_last = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("clr.valid", out_valid, 0);
    check("clr.ready", in_ready, 1);
    send(4'h3, 1);
    expect_result("f7", 4'h3, 4'h3, 8'd1, 3'b010);

    // Reset while holding a result
    out_ready = 1'b0;
    send(4'h4, 1);
    @(negedge clk);
    check("f8.valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("f8.rst.valid", out_valid, 0);
    check("f8.rst.cnt", cnt_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("f8.rst.idle", out_valid, 0);

    // Reset mid-frame discards the partial frame
    out_ready = 1'b1;
    send(4'h1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(4'h2, 1);
    expect_result("f9", 4'h2, 4'h2, 8'd1, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
